cond_route_sink: RTL and testbench

//  Clocked, parametrised conditional demux-with-sink. Each input token is paired with one control token.
//  The control token routes the data token to one of M buffered output channels, or discards it.

---
 rtl/cond_route_pkg.sv | 35 +++
 rtl/tok_fifo.sv | 55 +++++
 rtl/cond_route_sink.sv | 98 +++++++++
 tb/tb_cond_route_sink.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/cond_route_pkg.sv
// Shared definitions for cond_route_sink.
//   sel_width  : control select width for M channels (channels 0..M-1 plus one drop code)
//   drop_sel   : the select value that means "discard this token" (always M)
//   sel_kind   : classifies a select value as route / drop / illegal
//   sat_inc    : saturating increment for a counter of a given width
package cond_route_pkg;

  typedef enum logic [1:0] {
    SEL_ROUTE   = 2'd0,
    SEL_DROP    = 2'd1,
    SEL_ILLEGAL = 2'd2
  } sel_kind_e;

  function automatic int unsigned sel_width(input int unsigned m);
    return $clog2(m + 1);
  endfunction

  function automatic int unsigned drop_sel(input int unsigned m);
    return m;
  endfunction

  function automatic sel_kind_e sel_kind(input int unsigned sel, input int unsigned m);
    if (sel < m)                 return SEL_ROUTE;
    else if (sel == drop_sel(m)) return SEL_DROP;
    else                         return SEL_ILLEGAL;
  endfunction

  // Counter value carried in 64 bits; caller truncates to its own width.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] max;
    max = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= max) ? max : v + 64'd1;
  endfunction

endpackage

// File: rtl/tok_fifo.sv
// Per-channel token buffer.
//   clk, rst      : clock, asynchronous active-high reset (empties the buffer)
//   push_i, d_i   : write d_i when push_i and not full
//   pop_i         : discard the head entry when pop_i and not empty
//   full_o/empty_o: registered occupancy flags (no same-cycle bypass)
//   head_o        : oldest entry
module tok_fifo #(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [N-1:0] d_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [N-1:0] head_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [N-1:0] mem_q [DEPTH];
  // Pointers carry one extension bit above the address so full/empty differ.
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic         push_ok, pop_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    push_ok = push_i & ~full_o;
    pop_ok  = pop_i & ~empty_o;
    wr_d    = wr_q + (AW+1)'(push_ok);
    rd_d    = rd_q + (AW+1)'(pop_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: stale contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= d_i;
  end

endmodule

// File: rtl/cond_route_sink.sv
// Conditional demux with sink: each data token is consumed jointly with one
// control token that routes it to one of M buffered channels or discards it.
//   clk, rst        : clock, asynchronous active-high reset
//   r_i, a_i, d_i   : input token request / acknowledge / data
//   ctl_r, actl_i   : control request / acknowledge (a_i == actl_i)
//   ctl_sel         : 0..M-1 route, M drop, >M illegal (dropped, sets sel_err)
//   r_o, a_o, d_o   : per-channel output request / acknowledge / head data
//   clr_cnt         : synchronous clear of drop_cnt
//   drop_cnt        : saturating count of dropped tokens
//   sel_err         : sticky illegal-select flag
module cond_route_sink
  import cond_route_pkg::*;
#(
  parameter  int unsigned N     = 32,
  parameter  int unsigned M     = 2,
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned CNT_W = 16,
  localparam int unsigned SW    = sel_width(M)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r_i,
  output logic             a_i,
  input  logic [N-1:0]     d_i,
  input  logic             ctl_r,
  input  logic [SW-1:0]    ctl_sel,
  output logic             actl_i,
  output logic [M-1:0]     r_o,
  input  logic [M-1:0]     a_o,
  output logic [M*N-1:0]   d_o,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             sel_err
);

  logic [M-1:0]     full, empty, push;
  sel_kind_e        kind;
  logic             dest_full;
  logic             acc, drop;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             sel_err_q, sel_err_d;

  always_comb begin
    kind      = sel_kind(32'(ctl_sel), M);
    dest_full = 1'b0;
    for (int unsigned k = 0; k < M; k++) begin
      if (ctl_sel == SW'(k)) dest_full = full[k];
    end
    acc  = r_i & ctl_r & ~rst & ((kind != SEL_ROUTE) | ~dest_full);
    drop = acc & (kind != SEL_ROUTE);
    push = '0;
    for (int unsigned k = 0; k < M; k++) begin
      push[k] = acc & (kind == SEL_ROUTE) & (ctl_sel == SW'(k));
    end
  end

  assign a_i    = acc;
  assign actl_i = acc;

  // Clear takes priority but still counts a drop landing in the same cycle.
  always_comb begin
    if (clr_cnt)   drop_cnt_d = drop ? CNT_W'(1) : '0;
    else if (drop) drop_cnt_d = CNT_W'(sat_inc(64'(drop_cnt_q), CNT_W));
    else           drop_cnt_d = drop_cnt_q;
    sel_err_d = sel_err_q | (acc & (kind == SEL_ILLEGAL));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
      sel_err_q  <= 1'b0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      sel_err_q  <= sel_err_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign sel_err  = sel_err_q;

  for (genvar k = 0; k < M; k++) begin : g_ch
    tok_fifo #(
      .N    (N),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push_i (push[k]),
      .pop_i  (a_o[k]),
      .d_i    (d_i),
      .full_o (full[k]),
      .empty_o(empty[k]),
      .head_o (d_o[k*N +: N])
    );
    assign r_o[k] = ~empty[k];
  end

endmodule

// File: tb/tb_cond_route_sink.sv
// Scoreboard bench for cond_route_sink (M=2, DEPTH=2, CNT_W=3).
module tb_cond_route_sink;

  localparam int unsigned N = 32, M = 2, DEPTH = 2, CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             r_i, a_i, ctl_r, actl_i, clr_cnt, sel_err;
  logic [N-1:0]     d_i;
  logic [1:0]       ctl_sel;
  logic [M-1:0]     r_o, a_o;
  logic [M*N-1:0]   d_o;
  logic [CNT_W-1:0] drop_cnt;

  cond_route_sink #(.N(N), .M(M), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .r_i(r_i), .a_i(a_i), .d_i(d_i),
    .ctl_r(ctl_r), .ctl_sel(ctl_sel), .actl_i(actl_i),
    .r_o(r_o), .a_o(a_o), .d_o(d_o),
    .clr_cnt(clr_cnt), .drop_cnt(drop_cnt), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Scoreboard queues (one per channel) and model state.
  logic [N-1:0] q0[$];
  logic [N-1:0] q1[$];
  int unsigned  m_cnt = 0;
  logic         m_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called just after a negedge: drives one cycle of stimulus, checks the
  // DUT against the model, then advances the model over the next posedge.
  task automatic cycle(input logic r, input logic c, input logic [1:0] sel,
                       input logic [N-1:0] d, input logic [1:0] ao, input logic clr);
    logic exp_acc;
    logic drop;
    r_i = r; ctl_r = c; ctl_sel = sel; d_i = d; a_o = ao; clr_cnt = clr;
    #1;
    exp_acc = r && c && (sel >= 2'd2 ||
              (sel == 2'd0 ? q0.size() < DEPTH : q1.size() < DEPTH));
    check("a_i",    a_i,    exp_acc);
    check("actl_i", actl_i, exp_acc);
    check("r_o0", r_o[0], q0.size() != 0);
    check("r_o1", r_o[1], q1.size() != 0);
    if (q0.size() != 0) check("d_o0", d_o[N-1:0],   q0[0]);
    if (q1.size() != 0) check("d_o1", d_o[2*N-1:N], q1[0]);
    check("drop_cnt", drop_cnt, m_cnt);
    check("sel_err",  sel_err,  m_err);
    if (ao[0] && q0.size() != 0) void'(q0.pop_front());
    if (ao[1] && q1.size() != 0) void'(q1.pop_front());
    drop = 1'b0;
    if (exp_acc) begin
      case (sel)
        2'd0:    q0.push_back(d);
        2'd1:    q1.push_back(d);
        default: begin
          drop = 1'b1;
          if (sel == 2'd3) m_err = 1'b1;
        end
      endcase
    end
    if (clr)       m_cnt = drop ? 1 : 0;
    else if (drop) m_cnt = (m_cnt < 7) ? m_cnt + 1 : 7;
    @(negedge clk);
  endtask

  task automatic idle(input int unsigned n, input logic [1:0] ao);
    for (int unsigned i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'd0, '0, ao, 1'b0);
  endtask

  initial begin
    rst = 1'b1; r_i = 1'b1; ctl_r = 1'b1; ctl_sel = 2'd0; d_i = '0;
    a_o = '0; clr_cnt = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_a_i",      a_i,      1'b0);
    check("rst_actl_i",   actl_i,   1'b0);
    check("rst_r_o",      r_o,      2'b00);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_sel_err",  sel_err,  1'b0);
    r_i = 1'b0; ctl_r = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // 1: one token to each channel, consumers ready
    cycle(1, 1, 2'd0, 32'hA, 2'b11, 0);
    cycle(1, 1, 2'd1, 32'hB, 2'b11, 0);
    idle(3, 2'b11);

    // 2: channel 0 stalled, third token waits until after the first pop
    cycle(1, 1, 2'd0, 32'h100, 2'b00, 0);
    cycle(1, 1, 2'd0, 32'h101, 2'b00, 0);
    cycle(1, 1, 2'd0, 32'h102, 2'b00, 0);
    cycle(1, 1, 2'd0, 32'h102, 2'b00, 0);
    cycle(1, 1, 2'd0, 32'h102, 2'b01, 0);
    cycle(1, 1, 2'd0, 32'h102, 2'b00, 0);
    idle(4, 2'b01);

    // 3: five back-to-back drops, then clear coinciding with a drop
    for (int unsigned i = 0; i < 5; i++) cycle(1, 1, 2'd2, 32'h200 + i, 2'b11, 0);
    cycle(1, 1, 2'd2, 32'h2FF, 2'b11, 1);
    idle(1, 2'b11);

    // 4: saturation, then an illegal select counted as a drop
    cycle(0, 0, 2'd0, '0, 2'b11, 1);
    for (int unsigned i = 0; i < 9; i++) cycle(1, 1, 2'd2, 32'h300 + i, 2'b11, 0);
    cycle(1, 1, 2'd3, 32'h3FF, 2'b11, 0);
    idle(2, 2'b11);
    cycle(1, 1, 2'd0, 32'h400, 2'b11, 0);
    idle(2, 2'b11);

    // 5: data without control never consumes; control arrival accepts at once
    for (int unsigned i = 0; i < 4; i++) cycle(1, 0, 2'd1, 32'h500, 2'b11, 0);
    for (int unsigned i = 0; i < 4; i++) cycle(0, 1, 2'd1, 32'h501, 2'b11, 0);
    cycle(1, 1, 2'd1, 32'h502, 2'b11, 0);
    idle(2, 2'b11);

    // 6: two tokens parked in channel 1, asynchronous reset mid-stream
    cycle(1, 1, 2'd1, 32'h600, 2'b00, 0);
    cycle(1, 1, 2'd1, 32'h601, 2'b00, 0);
    cycle(1, 1, 2'd2, 32'h602, 2'b00, 0);
    r_i = 1'b1; ctl_r = 1'b1; ctl_sel = 2'd2;
    #2;
    rst = 1'b1;
    #1;
    check("arst_r_o",      r_o,      2'b00);
    check("arst_drop_cnt", drop_cnt, 0);
    check("arst_sel_err",  sel_err,  1'b0);
    check("arst_a_i",      a_i,      1'b0);
    check("arst_actl_i",   actl_i,   1'b0);
    q0.delete(); q1.delete(); m_cnt = 0; m_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(3, 2'b11);
    cycle(1, 1, 2'd1, 32'h700, 2'b11, 0);
    idle(2, 2'b11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
